// File: rtl/wb_burst_bridge_if.sv
// Wishbone bus bundle used on both sides of wb_burst_bridge.
// The master modport is the side that issues cycles; the slave modport answers them.
interface wb_burst_bridge_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] o_dat;
  logic [DATA_W-1:0] i_dat;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic              burst_8;
  logic              burst_4;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, adr, o_dat, we, sel, burst_8, burst_4,
    input  i_dat, ack, err
  );

  modport slave (
    input  cyc, stb, adr, o_dat, we, sel, burst_8, burst_4,
    output i_dat, ack, err
  );
endinterface

// File: rtl/wb_burst_bridge.sv
// wb_burst_bridge: same-clock Wishbone bridge with registered requests, bounded
// read bursts and a response FIFO so the slave can stream while the master drains.
// Optional feature: define WB_BRIDGE_TIMEOUT_EN to terminate a burst with error
// beats when the slave stays silent for TIMEOUT cycles.
module wb_burst_bridge #(
  parameter int                ADDR_W       = 24,
  parameter int                DATA_W       = 16,
  parameter int                MAX_BURST    = 8,
  parameter int                FIFO_DEPTH   = 8,
  parameter logic [ADDR_W-1:0] IGNORE_BELOW = 'h002000,
  parameter int                TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_burst_bridge_if.slave  m_wb,
  wb_burst_bridge_if.master s_wb
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_W + 1;

  if (MAX_BURST < 8 || FIFO_DEPTH < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("wb_burst_bridge: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, BUSY, TMO, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                prev_stb_q, prev_ack_q;
  logic                s_cyc_q, s_cyc_d;
  logic [ADDR_W-1:0]   s_adr_q, s_adr_d;
  logic [DATA_W-1:0]   s_dat_q, s_dat_d;
  logic                s_we_q, s_we_d;
  logic [SEL_W-1:0]    s_sel_q, s_sel_d;
  logic                s_b8_q, s_b8_d;
  logic                s_b4_q, s_b4_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                m_ack_q, m_ack_d, m_err_q, m_err_d;
  logic [DATA_W-1:0]   m_dat_q, m_dat_d;

  logic                s_stb, push, flush, fifo_pop, fifo_wr, bypass;
  logic [ENT_W-1:0]    push_ent;
  logic                fifo_empty, fifo_full, abort, m_rdy, slv_resp, new_req, tmo_hit;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign abort      = !m_wb.cyc && (state_q != IDLE);
  // The master accepts response beats only while it holds cyc and stb.
  assign m_rdy      = m_wb.cyc && m_wb.stb;
  assign slv_resp   = s_wb.ack || s_wb.err;
  assign new_req    = m_wb.stb && (!prev_stb_q || prev_ack_q) &&
                      (m_wb.adr >= IGNORE_BELOW) && (state_q == IDLE);

`ifdef WB_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  // Saturating silence counter: counts BUSY cycles since the last slave response.
  always_comb begin
    tmo_d = 8'h00;
    if (state_q == BUSY && !slv_resp) begin
      tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'h01;
    end
  end

  // Silence counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 8'h00;
    else     tmo_q <= tmo_d;
  end

  assign tmo_hit = (state_q == BUSY) && (tmo_q == 8'(TIMEOUT));
`else
  assign tmo_hit = 1'b0;
`endif

  // Request FSM: latch the master request, strobe the slave, count beats.
  always_comb begin
    state_d  = state_q;
    s_cyc_d  = s_cyc_q;
    s_adr_d  = s_adr_q;
    s_dat_d  = s_dat_q;
    s_we_d   = s_we_q;
    s_sel_d  = s_sel_q;
    s_b8_d   = s_b8_q;
    s_b4_d   = s_b4_q;
    beats_d  = beats_q;
    s_stb    = 1'b0;
    push     = 1'b0;
    push_ent = {s_wb.err, s_wb.i_dat};
    flush    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      s_cyc_d = 1'b0;
      beats_d = '0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_req) begin
            s_adr_d = m_wb.adr;
            s_dat_d = m_wb.o_dat;
            s_we_d  = m_wb.we;
            s_sel_d = m_wb.sel;
            s_b8_d  = m_wb.burst_8;
            s_b4_d  = m_wb.burst_4;
            beats_d = m_wb.we      ? CNT_W'(1) :
                      m_wb.burst_8 ? CNT_W'(8) :
                      m_wb.burst_4 ? CNT_W'(4) : CNT_W'(1);
            s_cyc_d = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (tmo_hit) begin
            s_cyc_d = 1'b0;
            if (beats_q != '0 && !fifo_full) begin
              push     = 1'b1;
              push_ent = {1'b1, {DATA_W{1'b0}}};
              beats_d  = beats_q - CNT_W'(1);
            end
            state_d = (beats_d == '0) ? DRAIN : TMO;
          end else begin
            s_stb = (beats_q != '0) && !fifo_full;
            if (slv_resp && beats_q != '0) begin
              push    = 1'b1;
              beats_d = beats_q - CNT_W'(1);
              if (beats_q == CNT_W'(1)) begin
                s_cyc_d = 1'b0;
                state_d = DRAIN;
              end
            end
          end
        end
        TMO: begin
          if (beats_q != '0 && !fifo_full) begin
            push     = 1'b1;
            push_ent = {1'b1, {DATA_W{1'b0}}};
            beats_d  = beats_q - CNT_W'(1);
          end
          if (beats_d == '0) state_d = DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && !m_ack_q && !m_err_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Response path: FIFO bookkeeping plus fall-through into the master response register.
  always_comb begin
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    fifo_wr  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    m_ack_d  = 1'b0;
    m_err_d  = 1'b0;
    m_dat_d  = m_dat_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      fifo_pop = !fifo_empty && m_rdy;
      bypass   = fifo_empty && push && m_rdy;
      fifo_wr  = push && !bypass;
      if (fifo_pop) begin
        {m_err_d, m_dat_d} = mem_q[rd_ptr_q];
        m_ack_d            = !m_err_d;
        rd_ptr_d           = rd_ptr_q + PTR_W'(1);
      end else if (bypass) begin
        {m_err_d, m_dat_d} = push_ent;
        m_ack_d            = !m_err_d;
      end
      if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_wr && !fifo_pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
      else if (!fifo_wr && fifo_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  // FIFO storage; entries are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= push_ent;
  end

  // State, latched request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_stb_q <= 1'b0;
      prev_ack_q <= 1'b0;
      s_cyc_q    <= 1'b0;
      s_adr_q    <= '0;
      s_dat_q    <= '0;
      s_we_q     <= 1'b0;
      s_sel_q    <= '0;
      s_b8_q     <= 1'b0;
      s_b4_q     <= 1'b0;
      beats_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      m_ack_q    <= 1'b0;
      m_err_q    <= 1'b0;
      m_dat_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_stb_q <= m_wb.stb;
      prev_ack_q <= m_ack_q || m_err_q;
      s_cyc_q    <= s_cyc_d;
      s_adr_q    <= s_adr_d;
      s_dat_q    <= s_dat_d;
      s_we_q     <= s_we_d;
      s_sel_q    <= s_sel_d;
      s_b8_q     <= s_b8_d;
      s_b4_q     <= s_b4_d;
      beats_q    <= beats_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      m_ack_q    <= m_ack_d;
      m_err_q    <= m_err_d;
      m_dat_q    <= m_dat_d;
    end
  end

  assign s_wb.cyc     = s_cyc_q;
  assign s_wb.stb     = s_stb;
  assign s_wb.adr     = s_adr_q;
  assign s_wb.o_dat   = s_dat_q;
  assign s_wb.we      = s_we_q;
  assign s_wb.sel     = s_sel_q;
  assign s_wb.burst_8 = s_b8_q;
  assign s_wb.burst_4 = s_b4_q;
  assign m_wb.i_dat   = m_dat_q;
  assign m_wb.ack     = m_ack_q;
  assign m_wb.err     = m_err_q;
endmodule

// File: tb/tb_wb_burst_bridge.sv
// Testbench for wb_burst_bridge: scripted master, reactive slave model and a
// response scoreboard. Build with WB_BRIDGE_TIMEOUT_EN to include the timeout case.
module tb_wb_burst_bridge;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_burst_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();
  wb_burst_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  wb_burst_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8), .FIFO_DEPTH(4),
    .IGNORE_BELOW(24'h002000), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .m_wb(m_bus), .s_wb(s_bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  int mon_cnt = 0;

  // slave model controls
  bit          slv_on = 1'b0;
  int          slv_delay = 0;
  logic [15:0] slv_base = '0;
  int          slv_seq = 0;
  int          slv_acks = 0;
  int          slv_wait = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic master_req(input logic [23:0] adr, input logic we, input logic [15:0] dat,
                            input logic [1:0] sel, input logic b8, input logic b4);
    m_bus.cyc = 1'b1; m_bus.stb = 1'b1; m_bus.adr = adr; m_bus.we = we;
    m_bus.o_dat = dat; m_bus.sel = sel; m_bus.burst_8 = b8; m_bus.burst_4 = b4;
  endtask

  task automatic master_idle();
    m_bus.cyc = 1'b0; m_bus.stb = 1'b0; m_bus.we = 1'b0;
    m_bus.burst_8 = 1'b0; m_bus.burst_4 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_resp(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && mon_cnt < n; i++) tick();
    chk(tag, 32'(mon_cnt), 32'(n));
  endtask

  task automatic slave_cfg(input bit on, input int dly, input logic [15:0] base);
    slv_on = on; slv_delay = dly; slv_base = base; slv_seq = 0; slv_acks = 0;
  endtask

  // Slave: answers strobes after slv_delay cycles and records the expected master beat.
  initial begin
    s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.i_dat = '0;
    forever begin
      @(negedge clk);
      s_bus.ack = 1'b0;
      if (slv_on && s_bus.stb) begin
        if (slv_wait >= slv_delay) begin
          s_bus.ack   = 1'b1;
          s_bus.i_dat = slv_base + 16'(slv_seq);
          exp_q.push_back({1'b0, s_bus.i_dat});
          slv_seq++;
          slv_acks++;
          slv_wait = 0;
        end else begin
          slv_wait++;
        end
      end else begin
        slv_wait = 0;
      end
    end
  end

  // Monitor: every master response beat is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (m_bus.ack || m_bus.err) begin
        mon_cnt++;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'({m_bus.err, m_bus.ack, m_bus.i_dat}), 32'h0);
        end else begin
          chk("resp_data", 32'({m_bus.err, m_bus.i_dat}), 32'(exp_q.pop_front()));
          chk("resp_one_hot", 32'(m_bus.ack ^ m_bus.err), 32'h1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int first;
    m_bus.cyc = 1'b0; m_bus.stb = 1'b0; m_bus.adr = '0; m_bus.o_dat = '0;
    m_bus.we = 1'b0; m_bus.sel = '0; m_bus.burst_8 = 1'b0; m_bus.burst_4 = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_s_cyc", 32'(s_bus.cyc), 32'h0);
    chk("rst_s_stb", 32'(s_bus.stb), 32'h0);
    chk("rst_m_resp", 32'({m_bus.ack, m_bus.err, m_bus.i_dat}), 32'h0);
    chk("rst_s_adr", 32'(s_bus.adr), 32'h0);
    rst = 1'b0;
    tick();

    // 1: single read
    slave_cfg(1'b1, 3, 16'hBEEF);
    mon_cnt = 0;
    master_req(24'h004000, 1'b0, 16'h0, 2'b11, 1'b0, 1'b0);
    tick();
    chk("t1_req_latency", 32'(s_bus.cyc), 32'h1);
    chk("t1_s_adr", 32'(s_bus.adr), 32'h004000);
    for (int i = 0; i < 20 && !m_bus.ack; i++) tick();
    chk("t1_ack_seen", 32'(m_bus.ack), 32'h1);
    chk("t1_cyc_drop", 32'(s_bus.cyc), 32'h0);
    master_idle();
    chk("t1_ack_count", 32'(mon_cnt), 32'h1);

    // 2: 8-burst with the master stalled
    slave_cfg(1'b1, 0, 16'h0001);
    mon_cnt = 0;
    master_req(24'h008000, 1'b0, 16'h0, 2'b11, 1'b1, 1'b0);
    tick();
    m_bus.stb = 1'b0;
    repeat (8) tick();
    chk("t2_stb_stalled", 32'(s_bus.stb), 32'h0);
    chk("t2_pushes_stalled", 32'(slv_acks), 32'h4);
    chk("t2_no_ack_stalled", 32'(mon_cnt), 32'h0);
    m_bus.stb = 1'b1;
    wait_resp("t2_resp_count", 8, 40);
    chk("t2_slave_beats", 32'(slv_acks), 32'h8);
    master_idle();

    // 3: write with burst flag set
    slave_cfg(1'b1, 1, 16'h7777);
    mon_cnt = 0;
    master_req(24'h005000, 1'b1, 16'h1234, 2'b01, 1'b1, 1'b0);
    tick();
    chk("t3_s_adr", 32'(s_bus.adr), 32'h005000);
    chk("t3_s_dat", 32'(s_bus.o_dat), 32'h1234);
    chk("t3_s_we", 32'(s_bus.we), 32'h1);
    chk("t3_s_sel", 32'(s_bus.sel), 32'h1);
    chk("t3_s_b8", 32'(s_bus.burst_8), 32'h1);
    wait_resp("t3_resp", 1, 20);
    master_idle();
    repeat (8) tick();
    chk("t3_single_ack", 32'(mon_cnt), 32'h1);
    chk("t3_single_beat", 32'(slv_acks), 32'h1);

    // 4: ignored address
    slave_cfg(1'b1, 0, 16'h5555);
    mon_cnt = 0;
    master_req(24'h001FFF, 1'b0, 16'h0, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_cyc_low", 32'(s_bus.cyc), 32'h0);
    end
    chk("t4_no_ack", 32'(mon_cnt), 32'h0);
    master_idle();

    // 5: abort after 3 beats, then a new request
    slave_cfg(1'b1, 0, 16'h0100);
    mon_cnt = 0;
    master_req(24'h00A000, 1'b0, 16'h0, 2'b11, 1'b1, 1'b0);
    wait_resp("t5_three_beats", 3, 30);
    m_bus.cyc = 1'b0;
    m_bus.stb = 1'b0;
    tick();
    exp_q.delete();
    chk("t5_cyc_drop", 32'(s_bus.cyc), 32'h0);
    n0 = mon_cnt;
    slave_cfg(1'b1, 0, 16'h0200);
    master_req(24'h00C000, 1'b0, 16'h0, 2'b11, 1'b0, 1'b0);
    tick();
    chk("t5_new_req", 32'(s_bus.cyc), 32'h1);
    wait_resp("t5_new_resp", n0 + 1, 20);
    master_idle();
    repeat (5) tick();
    chk("t5_no_late_acks", 32'(mon_cnt), 32'(n0 + 1));

    // 7: reset in the middle of a burst
    slave_cfg(1'b1, 0, 16'h0300);
    mon_cnt = 0;
    master_req(24'h00D000, 1'b0, 16'h0, 2'b11, 1'b1, 1'b0);
    wait_resp("t7_two_beats", 2, 30);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("t7_cyc_reset", 32'(s_bus.cyc), 32'h0);
    chk("t7_adr_reset", 32'(s_bus.adr), 32'h0);
    n0 = mon_cnt;
    rst = 1'b0;
    master_idle();
    repeat (5) tick();
    chk("t7_no_acks_after", 32'(mon_cnt), 32'(n0));

`ifdef WB_BRIDGE_TIMEOUT_EN
    // 6: silent slave on a 4-burst
    slave_cfg(1'b0, 0, 16'h0);
    mon_cnt = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(17'h10000);
    master_req(24'h00E000, 1'b0, 16'h0, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 10 && !s_bus.stb; i++) tick();
    chk("t6_stb_rise", 32'(s_bus.stb), 32'h1);
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (m_bus.err && first < 0) first = i;
    end
    chk("t6_err_offset", 32'(first), 32'd17);
    chk("t6_err_count", 32'(mon_cnt), 32'h4);
    master_idle();
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
